// File: rtl/phase_exec_if.sv
// Handshake and status bundle between the phase executor and its environment.
interface phase_exec_if #(
  parameter int CNT_W = 16
);
  logic [2:0]       phase_in;
  logic             run;
  logic             halt_req;
  logic             mem_op;
  logic             wb_en;
  logic             imem_ack;
  logic             dmem_ack;
  logic             phase_en;
  logic             imem_req;
  logic             dmem_req;
  logic             ir_we;
  logic             rf_re;
  logic             rf_we;
  logic             busy;
  logic             halted;
  logic             err;
  logic [CNT_W-1:0] retired;

  modport slave (
    input  phase_in, run, halt_req, mem_op, wb_en, imem_ack, dmem_ack,
    output phase_en, imem_req, dmem_req, ir_we, rf_re, rf_we,
           busy, halted, err, retired
  );

  modport master (
    output phase_in, run, halt_req, mem_op, wb_en, imem_ack, dmem_ack,
    input  phase_en, imem_req, dmem_req, ir_we, rf_re, rf_we,
           busy, halted, err, retired
  );
endinterface

// File: rtl/phase_exec_ctrl.sv
// Phase executor: decodes the one-hot sequencer phase into datapath strobes,
// runs the imem/dmem handshakes, stalls the sequencer while memory is busy,
// and owns run/halt control, a memory-wait timeout and a retired counter.
module phase_exec_ctrl #(
  parameter int CNT_W    = 16,
  parameter int WAIT_W   = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic         clk_i,
  input  logic         rst_i,
  phase_exec_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  logic              halt_q, halt_d;
  logic [CNT_W-1:0]  ret_q, ret_d;
  logic [2:0]        phase_q;

  logic ph_boot, ph_fetch, ph_dec, ph_exec, ph_ill;
  logic active, exec_done, pending, phase_chg, timeout, fault, halt_now;
  logic imem_req, dmem_req, ir_we, rf_re;

  assign ph_boot  = (bus.phase_in == 3'b000);
  assign ph_fetch = (bus.phase_in == 3'b001);
  assign ph_dec   = (bus.phase_in == 3'b010);
  assign ph_exec  = (bus.phase_in == 3'b100);
  assign ph_ill   = !(ph_boot | ph_fetch | ph_dec | ph_exec);

  // Reset gates the strobes immediately so a request drops in the reset cycle.
  assign active    = (state_q == S_RUN) && !rst_i;
  assign imem_req  = active & ph_fetch;
  assign dmem_req  = active & ph_exec & bus.mem_op;
  assign ir_we     = imem_req & bus.imem_ack;
  assign rf_re     = active & ph_dec;
  assign exec_done = active & ph_exec & (!bus.mem_op | bus.dmem_ack);

  assign pending   = (imem_req & !bus.imem_ack) | (dmem_req & !bus.dmem_ack);
  assign phase_chg = (bus.phase_in != phase_q);
  assign timeout   = pending & !phase_chg & (wait_q == WAIT_W'(WAIT_MAX));
  assign fault     = active & (ph_ill | timeout);
  assign halt_now  = halt_q | bus.halt_req;

  assign bus.imem_req = imem_req;
  assign bus.dmem_req = dmem_req;
  assign bus.ir_we    = ir_we;
  assign bus.rf_re    = rf_re;
  assign bus.rf_we    = exec_done & bus.wb_en;
  assign bus.phase_en = active & (ph_boot | ir_we | rf_re | exec_done);
  assign bus.busy     = (state_q == S_RUN);
  assign bus.halted   = (state_q == S_HALT);
  assign bus.err      = err_q;
  assign bus.retired  = ret_q;

  // Next-state: run/halt FSM, sticky error, halt latch, saturating retire count.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    halt_d  = halt_q | bus.halt_req;
    ret_d   = ret_q;
    case (state_q)
      S_IDLE: if (bus.run) state_d = S_RUN;
      S_RUN: begin
        if (fault) begin
          state_d = S_HALT;
          err_d   = 1'b1;
          halt_d  = 1'b0;
        end else if (exec_done) begin
          if (ret_q != {CNT_W{1'b1}}) ret_d = ret_q + 1'b1;
          if (halt_now) begin
            state_d = S_HALT;
            halt_d  = 1'b0;
          end
        end
      end
      S_HALT: if (bus.run && !err_q) begin
        state_d = S_RUN;
        halt_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Wait counter: consecutive unacknowledged cycles within the current phase.
  always_comb begin
    wait_d = wait_q;
    if (!pending || fault) wait_d = '0;
    else if (phase_chg)    wait_d = WAIT_W'(1);
    else                   wait_d = wait_q + 1'b1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      err_q   <= 1'b0;
      halt_q  <= 1'b0;
      ret_q   <= '0;
      phase_q <= 3'b000;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      halt_q  <= halt_d;
      ret_q   <= ret_d;
      phase_q <= bus.phase_in;
    end
  end
endmodule
